// File: rtl/pbs_digit_recomposer_if.sv
// Digit-in / coefficient-out stream bundle for the PBS digit recomposer.
// The master side feeds signed digits and consumes coefficients; the slave
// side is the recomposer itself.
interface pbs_digit_recomposer_if #(
  parameter int B_W  = 3,
  parameter int OP_W = 21
);
  // Digit stream (one decomposition level per beat)
  logic            in_vld;
  logic            in_rdy;
  logic [B_W:0]    in_digit;
  logic            in_last;
  // Coefficient stream
  logic            out_vld;
  logic            out_rdy;
  logic [OP_W-1:0] out_coef;

  modport master (
    output in_vld, in_digit, in_last, out_rdy,
    input  in_rdy, out_vld, out_coef
  );

  modport slave (
    input  in_vld, in_digit, in_last, out_rdy,
    output in_rdy, out_vld, out_coef
  );
endinterface

// File: rtl/pbs_digit_recomposer.sv
// Recomposes a coefficient modulo 2^OP_W from L signed base-2^B_W digits,
// most-significant level first. One digit per cycle; the finished coefficient
// is held in a single output register until the consumer takes it. Framing
// errors (early or missing in_last) raise a one-cycle err pulse and a sticky flag.
module pbs_digit_recomposer #(
  parameter int B_W  = 3,
  parameter int L    = 5,
  parameter int OP_W = 21
) (
  input  logic                  clk,
  input  logic                  a_rst_n,
  pbs_digit_recomposer_if.slave bus,
  output logic                  err,
  output logic                  err_sticky
);

  localparam int LVL_W = (L > 1) ? $clog2(L) : 1;
  localparam logic [LVL_W-1:0] LVL_LAST = LVL_W'(L - 1);

  // Every level must keep a non-negative weight inside the modulus.
  if (L * B_W > OP_W) begin : g_param_check
    $error("pbs_digit_recomposer: L*B_W must not exceed OP_W");
  end

  // lvl == 0 is IDLE (next digit starts a fresh coefficient), 1..L-1 is ACC.
  logic [LVL_W-1:0] lvl_q, lvl_d;
  logic [OP_W-1:0]  acc_q, acc_d;
  logic [OP_W-1:0]  out_coef_q, out_coef_d;
  logic             out_vld_q, out_vld_d;
  logic             err_q, err_d;
  logic             err_sticky_q, err_sticky_d;

  logic             in_rdy;
  logic             accept;
  logic             at_last;
  logic [OP_W-1:0]  digit_ext;
  logic [OP_W-1:0]  acc_sum;
  int               shamt;

  // State register: counter, accumulator, output holding register, error flags.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of the others.
  always_ff @(posedge clk or negedge a_rst_n) begin
    if (!a_rst_n) begin
      lvl_q        <= '0;
      acc_q        <= '0;
      out_coef_q   <= '0;
      out_vld_q    <= 1'b0;
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
    end else begin
      lvl_q        <= lvl_d;
      acc_q        <= acc_d;
      out_coef_q   <= out_coef_d;
      out_vld_q    <= out_vld_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
    end
  end

  // Next state: add the weighted digit, close the coefficient on the last
  // level, and abort the frame on an early in_last.
  // NOTE: every signal gets a default before the branches, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    accept    = bus.in_vld && in_rdy;
    at_last   = (lvl_q == LVL_LAST);
    digit_ext = OP_W'(signed'(bus.in_digit));
    shamt     = OP_W - (int'(lvl_q) + 1) * B_W;
    acc_sum   = ((lvl_q == '0) ? '0 : acc_q) + (digit_ext << shamt);

    lvl_d      = lvl_q;
    acc_d      = acc_q;
    out_coef_d = out_coef_q;
    out_vld_d  = out_vld_q && !bus.out_rdy;
    err_d      = 1'b0;

    if (accept) begin
      if (at_last) begin
        // Final level always completes; a missing in_last is still flagged.
        lvl_d      = '0;
        acc_d      = '0;
        out_coef_d = acc_sum;
        out_vld_d  = 1'b1;
        err_d      = !bus.in_last;
      end else if (bus.in_last) begin
        lvl_d = '0;
        acc_d = '0;
        err_d = 1'b1;
      end else begin
        lvl_d = lvl_q + LVL_W'(1);
        acc_d = acc_sum;
      end
    end

    err_sticky_d = err_sticky_q || err_d;
  end

  // Outputs: only the final digit can be back-pressured, and only while an
  // unconsumed coefficient is still sitting in the output register.
  always_comb begin
    in_rdy       = (lvl_q != LVL_LAST) || !out_vld_q || bus.out_rdy;
    bus.in_rdy   = in_rdy;
    bus.out_vld  = out_vld_q;
    bus.out_coef = out_coef_q;
    err          = err_q;
    err_sticky   = err_sticky_q;
  end

endmodule

// File: tb/tb_pbs_digit_recomposer.sv
// Self-checking bench for pbs_digit_recomposer: directed vectors, stall,
// framing errors, mid-frame reset and a randomized run, all scored through
// an expected-coefficient queue.
module tb_pbs_digit_recomposer;

  localparam int B_W  = 3;
  localparam int L    = 5;
  localparam int OP_W = 21;

  logic clk = 1'b0;
  logic a_rst_n;
  logic err;
  logic err_sticky;

  int total   = 0;
  int bad     = 0;
  int err_cnt = 0;
  bit rand_rdy = 1'b0;

  logic [OP_W-1:0] exp_q[$];

  pbs_digit_recomposer_if #(.B_W(B_W), .OP_W(OP_W)) bus ();

  pbs_digit_recomposer #(.B_W(B_W), .L(L), .OP_W(OP_W)) dut (
    .clk        (clk),
    .a_rst_n    (a_rst_n),
    .bus        (bus),
    .err        (err),
    .err_sticky (err_sticky)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference: sum of sign-extended digits at their level weights, mod 2^OP_W.
  function automatic logic [OP_W-1:0] model(input int d[L]);
    longint a = 0;
    for (int j = 0; j < L; j++) a += longint'(d[j]) <<< (OP_W - (j + 1) * B_W);
    return OP_W'(a);
  endfunction

  // Present one digit, wait (bounded) for acceptance, return at posedge+1.
  task automatic send(input int d, input bit last);
    int n = 0;
    bus.in_vld   = 1'b1;
    bus.in_digit = (B_W + 1)'(d);
    bus.in_last  = last;
    forever begin
      @(negedge clk);
      if (bus.in_rdy) break;
      n++;
      if (n > 100) begin
        check("rdy_timeout", bus.in_rdy, 1);
        break;
      end
    end
    @(posedge clk);
    #1;
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
  endtask

  // Full coefficient with in_last on the final level; queue its expectation.
  task automatic send_coef(input int d[L], input int bubbles);
    exp_q.push_back(model(d));
    for (int j = 0; j < L; j++) begin
      send(d[j], j == L - 1);
      repeat (bubbles) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: score each output handshake and count err pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (a_rst_n && bus.out_vld && bus.out_rdy) begin
        if (exp_q.size() == 0) check("sb_underflow", 64'(exp_q.size()), 64'd1);
        else check("coef", bus.out_coef, exp_q.pop_front());
      end
      if (err) err_cnt++;
    end
  end

  // Random consumer back-pressure, active only during the random phase.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_rdy) bus.out_rdy = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int v1[L] = '{1, 0, 0, 0, 0};
    int v2[L] = '{-1, 0, 0, 0, 1};
    int v3[L] = '{4, 4, 4, 4, 4};
    int v4[L] = '{0, 0, 0, 0, 2};
    int v5[L] = '{3, -2, 1, -4, 4};
    int rv[L];
    int n;

    // Reset state, including combinational in_rdy while reset is held.
    a_rst_n      = 1'b0;
    bus.in_vld   = 1'b0;
    bus.in_digit = '0;
    bus.in_last  = 1'b0;
    bus.out_rdy  = 1'b1;
    #12;
    check("rst_out_vld", bus.out_vld, 0);
    check("rst_out_coef", bus.out_coef, 0);
    check("rst_err", err, 0);
    check("rst_err_sticky", err_sticky, 0);
    check("rst_in_rdy", bus.in_rdy, 1);
    @(negedge clk);
    a_rst_n = 1'b1;
    idle(1);

    // [1,0,0,0,0]: output one cycle after the final accept.
    exp_q.push_back(21'h040000);
    for (int j = 0; j < L; j++) begin
      send(v1[j], j == L - 1);
      if (j == L - 2) check("v1_pre_vld", bus.out_vld, 0);
    end
    check("v1_vld", bus.out_vld, 1);
    check("v1_coef", bus.out_coef, 21'h040000);
    check("v1_err", err, 0);
    idle(2);

    // Wrap and all-maximum digits.
    exp_q.push_back(21'h1C0040);
    for (int j = 0; j < L; j++) send(v2[j], j == L - 1);
    exp_q.push_back(21'h124900);
    for (int j = 0; j < L; j++) send(v3[j], j == L - 1);
    idle(2);

    // Back-to-back with consumer stalled: second final digit must wait.
    bus.out_rdy = 1'b0;
    exp_q.push_back(21'h124900);
    for (int j = 0; j < L; j++) send(v3[j], j == L - 1);
    exp_q.push_back(21'h1C0040);
    for (int j = 0; j < L - 1; j++) send(v2[j], 1'b0);
    bus.in_vld   = 1'b1;
    bus.in_digit = (B_W + 1)'(v2[L-1]);
    bus.in_last  = 1'b1;
    repeat (3) begin
      @(posedge clk);
      #1;
      check("stall_in_rdy", bus.in_rdy, 0);
      check("stall_vld", bus.out_vld, 1);
      check("stall_coef", bus.out_coef, 21'h124900);
    end
    bus.out_rdy = 1'b1;
    @(negedge clk);
    check("stall_release_rdy", bus.in_rdy, 1);
    @(posedge clk);
    #1;
    bus.in_vld  = 1'b0;
    bus.in_last = 1'b0;
    check("reload_vld", bus.out_vld, 1);
    check("reload_coef", bus.out_coef, 21'h1C0040);
    idle(3);

    // Early in_last on level 2: err pulse, sticky, no output.
    send(1, 1'b0);
    send(0, 1'b0);
    send(0, 1'b1);
    check("early_err", err, 1);
    check("early_sticky", err_sticky, 1);
    check("early_no_vld", bus.out_vld, 0);
    idle(1);
    check("early_err_clr", err, 0);
    check("early_no_vld2", bus.out_vld, 0);
    exp_q.push_back(21'h040000);
    for (int j = 0; j < L; j++) send(v1[j], j == L - 1);
    check("recover_coef", bus.out_coef, 21'h040000);
    idle(2);

    // Missing in_last on the final level: completes, but flagged.
    exp_q.push_back(model(v5));
    for (int j = 0; j < L; j++) send(v5[j], 1'b0);
    check("nolast_vld", bus.out_vld, 1);
    check("nolast_err", err, 1);
    idle(3);

    // Reset mid-coefficient discards the partial sum and the sticky flag.
    send(3, 1'b0);
    send(2, 1'b0);
    a_rst_n = 1'b0;
    #1;
    check("midrst_in_rdy", bus.in_rdy, 1);
    check("midrst_sticky", err_sticky, 0);
    @(negedge clk);
    a_rst_n = 1'b1;
    idle(1);
    exp_q.push_back(21'h000080);
    for (int j = 0; j < L; j++) send(v4[j], j == L - 1);
    check("midrst_coef", bus.out_coef, 21'h000080);
    check("midrst_sticky_after", err_sticky, 0);
    idle(2);

    // Randomized digits, bubbles and back-pressure.
    rand_rdy = 1'b1;
    for (int k = 0; k < 30; k++) begin
      for (int j = 0; j < L; j++) rv[j] = int'($urandom_range(0, 8)) - 4;
      send_coef(rv, int'($urandom_range(0, 3)) == 0 ? 1 : 0);
    end
    rand_rdy = 1'b0;
    bus.out_rdy = 1'b1;

    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      idle(1);
      n++;
    end
    check("sb_drained", 64'(exp_q.size()), 0);
    check("err_count", 64'(err_cnt), 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pbs_digit_recomposer.md
PBS_DIGIT_RECOMPOSER -- requirements
Module: pbs_digit_recomposer

Interface
REQ-001 SHALL have parameter B_W, default 3 (KS_B_W): decomposition base width in bits.
REQ-002 SHALL have parameter L, default 5 (KS_L): number of decomposition levels.
REQ-003 SHALL have parameter OP_W, default 21 (MOD_KSK_W): recomposed coefficient width; the modulus is 2^OP_W.
REQ-004 SHALL have port clk, input, 1: sole clock; all logic is rising-edge.
REQ-005 SHALL have port a_rst_n, input, 1: asynchronous, active-low reset.
REQ-006 SHALL have port in_vld, input, 1: digit valid.
REQ-007 SHALL have port in_rdy, output, 1: digit accepted when in_vld & in_rdy.
REQ-008 SHALL have port in_digit, input, B_W+1: signed two's-complement digit in [-2^(B_W-1), 2^(B_W-1)].
REQ-009 SHALL have port in_last, input, 1: marks the final level of a coefficient.
REQ-010 SHALL have port out_vld, output, 1: coefficient valid.
REQ-011 SHALL have port out_rdy, input, 1: coefficient consumed when out_vld & out_rdy.
REQ-012 SHALL have port out_coef, output, OP_W: recomposed coefficient.
REQ-013 SHALL have port err, output, 1: one-cycle pulse on a framing error.
REQ-014 SHALL have port err_sticky, output, 1: set by any framing error, cleared only by reset.

Function
REQ-015 Digits SHALL arrive most-significant level first; level j (0..L-1) carries weight 2^(OP_W-(j+1)*B_W).
REQ-016 A level counter lvl (0..L-1) SHALL be kept; lvl=0 is IDLE, 1..L-1 is ACC.
REQ-017 On accepting a digit: acc = (lvl==0 ? 0 : acc) + sign_extend(in_digit) << (OP_W-(lvl+1)*B_W), modulo 2^OP_W (wrap, no saturation).
REQ-018 in_rdy = (lvl != L-1) | !out_vld | out_rdy; non-final digits are never back-pressured.
REQ-019 On accepting the level-(L-1) digit: out_coef <= final acc, out_vld <= 1 on the next edge, lvl <= 0; latency is 1 cycle.
REQ-020 out_vld SHALL stay asserted and out_coef SHALL stay stable until out_rdy; a simultaneous pop and new final digit SHALL reload out_coef with out_vld remaining 1.
REQ-021 Throughput SHALL be one digit per cycle, i.e. one coefficient per L cycles sustained.
REQ-022 in_last accepted with lvl < L-1 SHALL pulse err, set err_sticky, discard acc, reset lvl to 0, and produce no output.
REQ-023 in_last=0 accepted at lvl == L-1 SHALL still complete and output the coefficient, pulse err and set err_sticky.
REQ-024 in_vld=0 SHALL hold lvl and acc indefinitely (bubbles between levels are legal).
REQ-025 The design SHALL require L*B_W <= OP_W (elaboration-time assertion).

Reset
REQ-026 When a_rst_n=0: out_vld=0, out_coef=0, err=0, err_sticky=0, lvl=0, acc=0, and in_rdy=1 immediately (asynchronous).
REQ-027 Reset mid-coefficient SHALL discard the partial accumulation; the first digit after release SHALL be treated as level 0.

Verification
REQ-028 Digits [1,0,0,0,0], last on the 5th, out_rdy=1 -> out_coef=0x040000 one cycle after the 5th accept; err=0.
REQ-029 Digits [-1,0,0,0,1] -> out_coef=0x1C0040 (wrap); digits [4,4,4,4,4] -> out_coef=0x124900.
REQ-030 Two back-to-back coefficients with out_rdy=0 -> the 5th digit of the second coefficient stalls (in_rdy=0) and the 1st..4th are accepted; after out_rdy=1, both outputs appear in order, unchanged.
REQ-031 in_last on the 3rd digit -> err pulse for 1 cycle, err_sticky=1, no out_vld; the next 5 digits [1,0,0,0,0] produce 0x040000.
REQ-032 a_rst_n low after 2 digits, then digits [0,0,0,0,2] -> out_coef=0x000080, err_sticky=0.
